uart_tx_frame: RTL and testbench

Transmit-side counterpart of the UART command receiver. On a start pulse from the edge-processing pipeline it reads the processed 8-bit result frame buffer pixel by pixel. It serialises the frame into the UART TX FIFO as a framed byte stream: SOF, pixels, checksum, EOF. It pulses frame_tx_done when the last byte is accepted, which releases the receiver's wait-for-TX state.

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/uart_tx_frame.sv | 110 +++++++++++
 tb/tb_uart_tx_frame.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command receiver and the frame transmitter:
// framing bytes, RX command codes and the TX state encoding.
package uart_frame_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] EOF_BYTE = 8'h5A;

  // Command codes recognised by the UART receiver
  localparam logic [7:0] RX_CMD_LOAD = 8'hAA;
  localparam logic [7:0] RX_CMD_SEND = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    SEND_SOF,
    RD_REQ,
    RD_WAIT,
    SEND_PIX,
    SEND_CSUM,
    SEND_EOF,
    DONE
  } tx_state_t;

endpackage

// File: rtl/uart_tx_frame.sv
// Reads the processed frame buffer and streams it into the UART TX FIFO as
// SOF, pixels in address order, 8-bit wrap-around checksum, EOF.
module uart_tx_frame
  import uart_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 176,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  fb_re,
  output logic [ADDR_WIDTH-1:0] fb_rAddr,
  input  logic [DATA_WIDTH-1:0] fb_rData,
  output logic                  tx_wr_en,
  output logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic                  tx_full,
  output logic                  frame_tx_done,
  output logic                  busy
);

  localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

  tx_state_t             r_state;
  tx_state_t             w_nextState;
  logic [ADDR_WIDTH-1:0] r_pixelAddr;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic [DATA_WIDTH-1:0] r_pixReg;
  logic                  w_isSend;
  logic                  w_accept;

  // A byte leaves only when a SEND_* state meets a non-full FIFO; stalls hold state.
  assign w_isSend = (r_state == SEND_SOF) || (r_state == SEND_PIX) ||
                    (r_state == SEND_CSUM) || (r_state == SEND_EOF);
  assign w_accept = w_isSend && !tx_full;
  assign fb_rAddr = r_pixelAddr;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixelAddr <= '0;
      r_checksum  <= '0;
      r_pixReg    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pixelAddr <= '0;
            r_checksum  <= '0;
          end
        end
        RD_WAIT: r_pixReg <= fb_rData;
        SEND_PIX: begin
          // Address stops at the last pixel so it never reaches N
          if (w_accept) begin
            r_checksum <= r_checksum + r_pixReg;
            if (r_pixelAddr != LAST_ADDR) r_pixelAddr <= r_pixelAddr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState   = r_state;
    fb_re         = 1'b0;
    tx_wr_en      = w_accept;
    tx_wdata      = '0;
    frame_tx_done = 1'b0;
    busy          = (r_state != IDLE);
    case (r_state)
      IDLE:     if (start) w_nextState = SEND_SOF;
      SEND_SOF: begin
        tx_wdata = DATA_WIDTH'(SOF_BYTE);
        if (w_accept) w_nextState = RD_REQ;
      end
      RD_REQ: begin
        fb_re       = 1'b1;
        w_nextState = RD_WAIT;
      end
      RD_WAIT:  w_nextState = SEND_PIX;
      SEND_PIX: begin
        tx_wdata = r_pixReg;
        if (w_accept) w_nextState = (r_pixelAddr == LAST_ADDR) ? SEND_CSUM : RD_REQ;
      end
      SEND_CSUM: begin
        tx_wdata = r_checksum;
        if (w_accept) w_nextState = SEND_EOF;
      end
      SEND_EOF: begin
        tx_wdata = DATA_WIDTH'(EOF_BYTE);
        if (w_accept) w_nextState = DONE;
      end
      DONE: begin
        frame_tx_done = 1'b1;
        w_nextState   = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame on a 4x2 image: a byte-stream
// scoreboard plus a busy/read-order model, with directed stall and reset cases.
module tb_uart_tx_frame;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          fb_re;
  logic [AW-1:0] fb_rAddr;
  logic [7:0]    fbData;
  logic          tx_wr_en;
  logic [7:0]    tx_wdata;
  logic          tx_full;
  logic          frame_tx_done;
  logic          busy;

  uart_tx_frame #(
    .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .fb_re(fb_re), .fb_rAddr(fb_rAddr), .fb_rData(fbData),
    .tx_wr_en(tx_wr_en), .tx_wdata(tx_wdata), .tx_full(tx_full),
    .frame_tx_done(frame_tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [NPIX];
  int tests = 0;
  int fails = 0;
  int cycle = 0;
  bit checkOn = 1'b0;

  logic [7:0] expQ[$];
  logic [7:0] capBytes[$];
  int readCyc[$];
  int expReadAddr = 0;
  int readCount = 0;
  int doneCount = 0;
  int lastWriteCycle = 0;
  int sofCycle = 0;
  int startCycle = 0;
  bit expBusy = 1'b0;
  int idx;
  int rc;
  logic [7:0] expByte;

  // Frame buffer returns data the cycle after a read enable
  always @(posedge clk) if (fb_re) fbData <= mem[fb_rAddr];
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Loads an image, queues the expected byte stream and pulses start
  task automatic applyStimulus(input int mode);
    int sum;
    sum = 0;
    for (int a = 0; a < NPIX; a++) begin
      case (mode)
        0:       mem[a] = 8'(a * 16 + 1);
        1:       mem[a] = 8'hFF;
        default: mem[a] = 8'h00;
      endcase
      sum += mem[a];
    end
    capBytes.delete();
    readCyc.delete();
    expReadAddr = 0;
    readCount = 0;
    expQ.push_back(8'hA5);
    for (int a = 0; a < NPIX; a++) expQ.push_back(mem[a]);
    expQ.push_back(8'(sum % 256));
    expQ.push_back(8'h5A);
    @(posedge clk); #1 start = 1'b1;
    startCycle = cycle;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic waitWrite(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (tx_wr_en && tx_wdata == b) seen = 1'b1;
    end
    checkOutput("wait_write_timeout", {31'd0, seen}, 1);
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 1000 && doneCount < target; i++) @(negedge clk);
    checkOutput("wait_done_timeout", {31'd0, doneCount >= target}, 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, {31'd0, tx_wr_en}, 0);
    checkOutput({tag, "_wdata"}, {24'd0, tx_wdata}, 0);
    checkOutput({tag, "_fb_re"}, {31'd0, fb_re}, 0);
    checkOutput({tag, "_fb_addr"}, {{(32-AW){1'b0}}, fb_rAddr}, 0);
    checkOutput({tag, "_done"}, {31'd0, frame_tx_done}, 0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // Per-cycle compare against the scoreboard and the busy/read-order model
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      if (tx_wr_en) begin
        checkOutput("wr_while_full", {31'd0, tx_full}, 0);
        if (expQ.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL extra_write: got %02h expected no write", tx_wdata);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("stream_byte", {24'd0, tx_wdata}, {24'd0, expByte});
        end
        idx = capBytes.size();
        if (idx == 0) sofCycle = cycle;
        if (idx >= 1 && idx <= NPIX) begin
          if (readCyc.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL pixel_without_read: got write %0d expected a prior read", idx);
          end else begin
            rc = readCyc.pop_front();
            checkOutput("read_to_write_ge2", {31'd0, (cycle - rc) >= 2}, 1);
          end
        end
        capBytes.push_back(tx_wdata);
        lastWriteCycle = cycle;
      end
      if (fb_re) begin
        checkOutput("read_addr", {{(32-AW){1'b0}}, fb_rAddr}, expReadAddr);
        expReadAddr++;
        readCount++;
        readCyc.push_back(cycle);
      end
      if (frame_tx_done) begin
        doneCount++;
        checkOutput("done_after_eof", cycle - lastWriteCycle, 1);
        checkOutput("done_queue_empty", expQ.size(), 0);
      end
      if (reset) begin
        expQ.delete();
        readCyc.delete();
        expBusy = 1'b0;
        expReadAddr = 0;
      end else if (frame_tx_done) expBusy = 1'b0;
      else if (start && !expBusy) expBusy = 1'b1;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; tx_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1 reset = 1'b0;
    checkOn = 1'b1;

    $display("[TB] basic frame");
    applyStimulus(0);
    waitDone(1);
    repeat (3) @(posedge clk);
    checkOutput("basic_len", capBytes.size(), 11);
    checkOutput("basic_sof", {24'd0, capBytes[0]}, 32'hA5);
    checkOutput("basic_pix0", {24'd0, capBytes[1]}, 32'h01);
    checkOutput("basic_pix7", {24'd0, capBytes[8]}, 32'h71);
    checkOutput("basic_csum", {24'd0, capBytes[9]}, 32'hC8);
    checkOutput("basic_eof", {24'd0, capBytes[10]}, 32'h5A);
    checkOutput("sof_latency", sofCycle - startCycle, 1);
    checkOutput("basic_reads", readCount, 8);
    checkOutput("basic_done_cnt", doneCount, 1);

    $display("[TB] backpressure");
    applyStimulus(0);
    waitWrite(8'h11);
    repeat (3) @(posedge clk);
    #1 tx_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_pix_wr_en", {31'd0, tx_wr_en}, 0);
      checkOutput("stall_pix_wdata", {24'd0, tx_wdata}, 32'h21);
    end
    @(posedge clk); #1 tx_full = 1'b0;
    waitWrite(8'hC8);
    @(posedge clk); #1 tx_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_eof_wdata", {24'd0, tx_wdata}, 32'h5A);
      checkOutput("stall_eof_done", {31'd0, frame_tx_done}, 0);
    end
    @(posedge clk); #1 tx_full = 1'b0;
    waitDone(2);
    repeat (3) @(posedge clk);
    checkOutput("bp_len", capBytes.size(), 11);
    checkOutput("bp_reads", readCount, 8);

    $display("[TB] checksum wrap");
    applyStimulus(1);
    waitDone(3);
    repeat (3) @(posedge clk);
    checkOutput("csum_ff", {24'd0, capBytes[9]}, 32'hF8);
    applyStimulus(2);
    waitDone(4);
    repeat (3) @(posedge clk);
    checkOutput("csum_00", {24'd0, capBytes[9]}, 32'h00);

    $display("[TB] start while busy");
    applyStimulus(0);
    waitWrite(8'h21);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 500 && !frame_tx_done; i++) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    checkOutput("busy_start_len", capBytes.size(), 11);
    checkOutput("busy_start_done", doneCount, 5);

    $display("[TB] reset mid-frame");
    applyStimulus(0);
    waitWrite(8'h31);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("midreset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    checkOutput("midreset_len", capBytes.size(), 5);
    checkOutput("midreset_done", doneCount, 5);
    applyStimulus(0);
    waitDone(6);
    repeat (3) @(posedge clk);
    checkOutput("fresh_len", capBytes.size(), 11);
    checkOutput("fresh_sof", {24'd0, capBytes[0]}, 32'hA5);
    checkOutput("fresh_pix0", {24'd0, capBytes[1]}, 32'h01);
    checkOutput("fresh_reads", readCount, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
